// File: rtl/uart_char_rx.sv
// 8N1 serial character receiver: oversampled start validation, LSB-first framing,
// a small byte FIFO drained over valid/ready, and a saturating received-character count.
module uart_char_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       rx,
   input  logic       err_clr,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic [7:0] chars_received
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT/2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;

   state_t        state, next_state;
   logic          sync1, rx_s;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          sample_bit, push, frame_set;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          empty, full, pop, do_push, drop;

   // Synchronizer resets to the idle (high) line level so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= rx;
         rx_s  <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      sample_bit = 1'b0;
      push       = 1'b0;
      frame_set  = 1'b0;
      case (state)
         ST_IDLE:  if (rx_s == 1'b0) next_state = ST_START;
         ST_START: if (bit_cnt == CNT_HALF) next_state = rx_s ? ST_IDLE : ST_DATA;
         ST_DATA: begin
            if (bit_cnt == CNT_LAST) begin
               sample_bit = 1'b1;
               if (bit_idx == 3'd7) next_state = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_cnt == CNT_LAST) begin
               if (rx_s) begin
                  push       = 1'b1;
                  next_state = ST_IDLE;
               end else begin
                  frame_set  = 1'b1;
                  next_state = ST_BREAK;
               end
            end
         end
         ST_BREAK: if (rx_s) next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
      // Disable overrides the transition only; a push decided this cycle still lands.
      if (!ena) next_state = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         if (next_state != state || sample_bit) bit_cnt <= '0;
         else                                   bit_cnt <= bit_cnt + CW'(1);
         if (state != ST_DATA) bit_idx <= '0;
         else if (sample_bit)  bit_idx <= bit_idx + 3'd1;
         if (sample_bit) shift[bit_idx] <= rx_s;
      end
   end

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop      = !empty && rx_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign do_push  = push && (!full || pop);
   assign drop     = push && full && !pop;
   assign rx_valid = !empty;
   assign rx_data  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         chars_received <= '0;
         frame_err      <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= shift;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
            if (chars_received != 8'hFF) chars_received <= chars_received + 8'd1;
         end
         if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
         if (frame_set)    frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
         if (drop)         overrun   <= 1'b1;
         else if (err_clr) overrun   <= 1'b0;
      end
   end

endmodule
